// File: rtl/alu_accum_ctrl.sv
// Command-driven accumulator controller wrapped around an external combinational 8-bit ALU.
// Optional zero/negative result flags are compiled in when ALU_FLAGS_EN is defined.
module alu_accum_ctrl #(
  parameter logic [7:0] ACC_INIT = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [7:0]       acc_q,
  output logic [CNT_W-1:0] ops_done
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero_flag,
  output logic             neg_flag
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] acc;
  logic       op_start;
  logic       res_wr;
  logic [7:0] res_nxt;

  // A load skips EXEC and writes its value straight into acc/res_data.
  assign op_start = (state_q == IDLE) && cmd_valid && !cmd_load;
  assign res_wr   = ((state_q == IDLE) && cmd_valid && cmd_load) || (state_q == EXEC);
  assign res_nxt  = (state_q == EXEC) ? alu_y : cmd_data;

  assign alu_a = acc;
  assign acc_q = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_load ? RESP : EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE:    cmd_ready = 1'b1;
      RESP:    res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= ACC_INIT;
      alu_b    <= 8'h00;
      alu_sel  <= 3'b000;
      res_data <= 8'h00;
      ops_done <= '0;
    end else begin
      if (op_start) begin
        alu_b   <= cmd_data;
        alu_sel <= cmd_op;
      end
      if (res_wr) begin
        acc      <= res_nxt;
        res_data <= res_nxt;
      end
      if ((state_q == RESP) && res_ready) ops_done <= ops_done + CNT_W'(1);
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else if (res_wr) begin
      zero_flag <= (res_nxt == 8'h00);
      neg_flag  <= res_nxt[7];
    end
  end
`endif

endmodule
